// File: rtl/instr_encoder_if.sv
// Stream bundle for the instruction encoder: the input field stream, the
// address-load side channel, the encoded output stream and the error counter.
interface instr_encoder_if #(
  parameter int ERR_CNT_W = 16
);
  logic                 in_valid;
  logic                 in_ready;
  logic [3:0]           in_class;
  logic [2:0]           in_funct3;
  logic                 in_alt;
  logic [4:0]           in_rd;
  logic [4:0]           in_rs1;
  logic [4:0]           in_rs2;
  logic [31:0]          in_imm;
  logic                 addr_load;
  logic [31:0]          base_addr;
  logic                 out_valid;
  logic                 out_ready;
  logic [31:0]          out_instr;
  logic [31:0]          out_addr;
  logic                 out_err;
  logic [ERR_CNT_W-1:0] err_count;

  // Encoder side
  modport slave (
    input  in_valid, in_class, in_funct3, in_alt, in_rd, in_rs1, in_rs2, in_imm,
           addr_load, base_addr, out_ready,
    output in_ready, out_valid, out_instr, out_addr, out_err, err_count
  );

  // Producer / consumer side
  modport master (
    output in_valid, in_class, in_funct3, in_alt, in_rd, in_rs1, in_rs2, in_imm,
           addr_load, base_addr, out_ready,
    input  in_ready, out_valid, out_instr, out_addr, out_err, err_count
  );
endinterface

// File: rtl/instr_encoder.sv
// RV32I instruction word assembler: decoded fields in, 32-bit word out with a
// running word address, per-word legality checking and a saturating error count.
module instr_encoder #(
  parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
  parameter int          ERR_CNT_W  = 16
) (
  input logic              clk,
  input logic              rst_n,
  instr_encoder_if.slave   bus
);

  typedef enum logic [3:0] {
    C_RTYPE  = 4'd0,
    C_ITYPE  = 4'd1,
    C_LOAD   = 4'd2,
    C_STORE  = 4'd3,
    C_BRANCH = 4'd4,
    C_JAL    = 4'd5,
    C_JALR   = 4'd6,
    C_LUI    = 4'd7,
    C_AUIPC  = 4'd8
  } cls_e;

  localparam logic [31:0] NOP      = 32'h0000_0013;
  localparam logic [6:0]  OP_R     = 7'b0110011;
  localparam logic [6:0]  OP_I     = 7'b0010011;
  localparam logic [6:0]  OP_LOAD  = 7'b0000011;
  localparam logic [6:0]  OP_STORE = 7'b0100011;
  localparam logic [6:0]  OP_BR    = 7'b1100011;
  localparam logic [6:0]  OP_JAL   = 7'b1101111;
  localparam logic [6:0]  OP_JALR  = 7'b1100111;
  localparam logic [6:0]  OP_LUI   = 7'b0110111;
  localparam logic [6:0]  OP_AUIPC = 7'b0010111;
  localparam logic [6:0]  F7_ALT   = 7'b0100000;

  logic [31:0]          r_instr;
  logic [31:0]          r_addr;
  logic                 r_valid;
  logic                 r_err;
  logic [31:0]          r_cnt;
  logic [ERR_CNT_W-1:0] r_err_cnt;

  logic        w_accept;
  logic [31:0] w_cur_addr;
  logic [31:0] w_raw;
  logic [31:0] w_instr;
  logic        w_err;
  logic        w_fit12;
  logic        w_fit13;
  logic        w_fit21;
  logic [31:0] w_imm;
  logic [2:0]  w_f3;
  logic [6:0]  w_f7;

  assign w_imm = bus.in_imm;
  assign w_f3  = bus.in_funct3;
  assign w_f7  = bus.in_alt ? F7_ALT : 7'b0000000;

  // Immediate must be the sign extension of the class's field width
  assign w_fit12 = (w_imm[31:11] == {21{w_imm[11]}});
  assign w_fit13 = (w_imm[31:12] == {20{w_imm[12]}});
  assign w_fit21 = (w_imm[31:20] == {12{w_imm[20]}});

  assign bus.in_ready = !r_valid || bus.out_ready;
  assign w_accept     = bus.in_valid && bus.in_ready;
  // A same-cycle load overrides the counter for the word being accepted
  assign w_cur_addr   = bus.addr_load ? bus.base_addr : r_cnt;

  // Field packing and legality check per instruction class
  always_comb begin
    w_raw = NOP;
    w_err = 1'b0;
    case (bus.in_class)
      C_RTYPE: begin
        w_raw = {w_f7, bus.in_rs2, bus.in_rs1, w_f3, bus.in_rd, OP_R};
        w_err = bus.in_alt && !(w_f3 == 3'b000 || w_f3 == 3'b101);
      end
      C_ITYPE: begin
        if (w_f3 == 3'b001 || w_f3 == 3'b101) begin
          // Shift-immediate: shamt in [24:20], funct7 carries SRAI's alt bit
          w_raw = {w_f7, w_imm[4:0], bus.in_rs1, w_f3, bus.in_rd, OP_I};
          w_err = !w_fit12 || (w_imm[11:5] != 7'd0) ||
                  (w_f3 == 3'b001 && bus.in_alt);
        end else begin
          w_raw = {w_imm[11:0], bus.in_rs1, w_f3, bus.in_rd, OP_I};
          w_err = !w_fit12 || bus.in_alt;
        end
      end
      C_LOAD: begin
        w_raw = {w_imm[11:0], bus.in_rs1, w_f3, bus.in_rd, OP_LOAD};
        w_err = !w_fit12 || (w_f3 == 3'b011) || (w_f3 == 3'b110) || (w_f3 == 3'b111);
      end
      C_STORE: begin
        w_raw = {w_imm[11:5], bus.in_rs2, bus.in_rs1, w_f3, w_imm[4:0], OP_STORE};
        w_err = !w_fit12 || w_f3[2] || (w_f3 == 3'b011);
      end
      C_BRANCH: begin
        w_raw = {w_imm[12], w_imm[10:5], bus.in_rs2, bus.in_rs1, w_f3,
                 w_imm[4:1], w_imm[11], OP_BR};
        w_err = !w_fit13 || w_imm[0] || (w_f3 == 3'b010) || (w_f3 == 3'b011);
      end
      C_JAL: begin
        w_raw = {w_imm[20], w_imm[10:1], w_imm[11], w_imm[19:12], bus.in_rd, OP_JAL};
        w_err = !w_fit21 || w_imm[0];
      end
      C_JALR: begin
        w_raw = {w_imm[11:0], bus.in_rs1, 3'b000, bus.in_rd, OP_JALR};
        w_err = !w_fit12;
      end
      C_LUI: begin
        w_raw = {w_imm[31:12], bus.in_rd, OP_LUI};
        w_err = (w_imm[11:0] != 12'd0);
      end
      C_AUIPC: begin
        w_raw = {w_imm[31:12], bus.in_rd, OP_AUIPC};
        w_err = (w_imm[11:0] != 12'd0);
      end
      default: begin
        w_raw = NOP;
        w_err = 1'b1;
      end
    endcase
  end

  assign w_instr = w_err ? NOP : w_raw;

  // Output register: load on accept, drain when consumed, hold under backpressure
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_instr <= 32'd0;
      r_addr  <= 32'd0;
      r_err   <= 1'b0;
    end else if (w_accept) begin
      r_valid <= 1'b1;
      r_instr <= w_instr;
      r_addr  <= w_cur_addr;
      r_err   <= w_err;
    end else if (bus.out_ready) begin
      r_valid <= 1'b0;
    end
  end

  // Word address counter: each accepted word consumes one address
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= RESET_ADDR;
    end else if (w_accept) begin
      r_cnt <= w_cur_addr + 32'd4;
    end else if (bus.addr_load) begin
      r_cnt <= bus.base_addr;
    end
  end

  // Saturating count of accepted errored words
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_cnt <= '0;
    end else if (w_accept && w_err && (r_err_cnt != {ERR_CNT_W{1'b1}})) begin
      r_err_cnt <= r_err_cnt + 1'b1;
    end
  end

  assign bus.out_valid = r_valid;
  assign bus.out_instr = r_instr;
  assign bus.out_addr  = r_addr;
  assign bus.out_err   = r_err;
  assign bus.err_count = r_err_cnt;

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: directed literal cases plus randomized traffic
// checked every cycle against a field-level reference model.
module tb_instr_encoder;

  localparam logic [31:0] RA = 32'h0000_0100;
  localparam int          EW = 16;

  logic clk;
  logic rst_n;
  bit   chk_en;
  int   n_checks;
  int   n_errs;

  instr_encoder_if #(.ERR_CNT_W(EW)) ifc();

  instr_encoder #(.RESET_ADDR(RA), .ERR_CNT_W(EW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit fits(input longint v, input int n);
    return (v >= -(longint'(1) << (n - 1))) && (v < (longint'(1) << (n - 1)));
  endfunction

  // Reference encoder built from the ISA field placement with shifts and masks
  function automatic logic [32:0] model_enc(input int unsigned cls, input int unsigned f3,
                                            input bit alt, input int unsigned rd,
                                            input int unsigned rs1, input int unsigned rs2,
                                            input logic [31:0] imm);
    longint      v;
    int unsigned u;
    int unsigned w;
    bit          bad;
    v   = longint'($signed(imm));
    u   = imm;
    w   = 0;
    bad = 1'b0;
    case (cls)
      0: begin
        w = 32'h33 | rd << 7 | f3 << 12 | rs1 << 15 | rs2 << 20 | (alt ? 32'h4000_0000 : 0);
        bad = alt && f3 != 0 && f3 != 5;
      end
      1: begin
        if (f3 == 1 || f3 == 5) begin
          w = 32'h13 | rd << 7 | f3 << 12 | rs1 << 15 | (u & 31) << 20 | (alt ? 32'h4000_0000 : 0);
          bad = !(v >= 0 && v < 32) || (f3 == 1 && alt);
        end else begin
          w = 32'h13 | rd << 7 | f3 << 12 | rs1 << 15 | (u & 32'hFFF) << 20;
          bad = alt || !fits(v, 12);
        end
      end
      2: begin
        w = 32'h03 | rd << 7 | f3 << 12 | rs1 << 15 | (u & 32'hFFF) << 20;
        bad = !fits(v, 12) || f3 == 3 || f3 > 5;
      end
      3: begin
        w = 32'h23 | (u & 31) << 7 | f3 << 12 | rs1 << 15 | rs2 << 20 | ((u >> 5) & 127) << 25;
        bad = !fits(v, 12) || f3 > 2;
      end
      4: begin
        w = 32'h63 | ((u >> 11) & 1) << 7 | ((u >> 1) & 15) << 8 | f3 << 12 | rs1 << 15 |
            rs2 << 20 | ((u >> 5) & 63) << 25 | ((u >> 12) & 1) << 31;
        bad = !fits(v, 13) || (u & 1) != 0 || f3 == 2 || f3 == 3;
      end
      5: begin
        w = 32'h6F | rd << 7 | ((u >> 12) & 255) << 12 | ((u >> 11) & 1) << 20 |
            ((u >> 1) & 1023) << 21 | ((u >> 20) & 1) << 31;
        bad = !fits(v, 21) || (u & 1) != 0;
      end
      6: begin
        w = 32'h67 | rd << 7 | rs1 << 15 | (u & 32'hFFF) << 20;
        bad = !fits(v, 12);
      end
      7, 8: begin
        w = (cls == 7 ? 32'h37 : 32'h17) | rd << 7 | (u & 32'hFFFF_F000);
        bad = (u & 32'hFFF) != 0;
      end
      default: bad = 1'b1;
    endcase
    if (bad) w = 32'h13;
    return {bad, w};
  endfunction

  // Cycle model of the output register, address counter and error counter
  bit          m_valid;
  logic [31:0] m_instr;
  logic [31:0] m_addr;
  bit          m_err;
  logic [31:0] m_cnt;
  int          m_errc;

  always @(negedge clk) begin
    logic [32:0] e;
    logic [31:0] cur;
    bit          acc;
    if (chk_en) begin
      if (!rst_n) begin
        m_valid = 1'b0; m_instr = '0; m_addr = '0; m_err = 1'b0; m_cnt = RA; m_errc = 0;
        chk("rst_out_valid", 32'(ifc.out_valid), 32'd0);
        chk("rst_out_instr", ifc.out_instr, 32'd0);
        chk("rst_out_addr", ifc.out_addr, 32'd0);
        chk("rst_out_err", 32'(ifc.out_err), 32'd0);
        chk("rst_err_count", 32'(ifc.err_count), 32'd0);
      end else begin
        chk("out_valid", 32'(ifc.out_valid), 32'(m_valid));
        if (m_valid) begin
          chk("out_instr", ifc.out_instr, m_instr);
          chk("out_addr", ifc.out_addr, m_addr);
          chk("out_err", 32'(ifc.out_err), 32'(m_err));
        end
        chk("err_count", 32'(ifc.err_count), 32'(m_errc));
        chk("in_ready", 32'(ifc.in_ready), 32'(!m_valid || ifc.out_ready));
        acc = ifc.in_valid && (!m_valid || ifc.out_ready);
        cur = ifc.addr_load ? ifc.base_addr : m_cnt;
        if (acc) begin
          e = model_enc(ifc.in_class, ifc.in_funct3, ifc.in_alt, ifc.in_rd,
                        ifc.in_rs1, ifc.in_rs2, ifc.in_imm);
          m_valid = 1'b1;
          m_instr = e[31:0];
          m_err   = e[32];
          m_addr  = cur;
          m_cnt   = cur + 32'd4;
          if (e[32] && m_errc < (1 << EW) - 1) m_errc++;
        end else begin
          if (ifc.out_ready) m_valid = 1'b0;
          if (ifc.addr_load) m_cnt = ifc.base_addr;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic [3:0] cls, input logic [2:0] f3, input logic alt,
                        input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [31:0] imm);
    ifc.in_valid  = 1'b1;
    ifc.in_class  = cls;
    ifc.in_funct3 = f3;
    ifc.in_alt    = alt;
    ifc.in_rd     = rd;
    ifc.in_rs1    = rs1;
    ifc.in_rs2    = rs2;
    ifc.in_imm    = imm;
  endtask

  task automatic send_chk(input string nm, input logic [3:0] cls, input logic [2:0] f3,
                          input logic alt, input logic [4:0] rd, input logic [4:0] rs1,
                          input logic [4:0] rs2, input logic [31:0] imm,
                          input logic [31:0] exp_i, input logic [31:0] exp_a, input bit exp_e);
    set_in(cls, f3, alt, rd, rs1, rs2, imm);
    chk({nm, "_in_ready"}, 32'(ifc.in_ready), 32'd1);
    tick();
    chk({nm, "_valid"}, 32'(ifc.out_valid), 32'd1);
    chk({nm, "_instr"}, ifc.out_instr, exp_i);
    chk({nm, "_addr"}, ifc.out_addr, exp_a);
    chk({nm, "_err"}, 32'(ifc.out_err), 32'(exp_e));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("reset_async_valid", 32'(ifc.out_valid), 32'd0);
    chk("reset_async_errcnt", 32'(ifc.err_count), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    logic [32:0] pin;
    n_checks = 0;
    n_errs   = 0;
    chk_en   = 1'b0;
    rst_n    = 1'b1;
    ifc.in_valid = 1'b0; ifc.in_class = '0; ifc.in_funct3 = '0; ifc.in_alt = 1'b0;
    ifc.in_rd = '0; ifc.in_rs1 = '0; ifc.in_rs2 = '0; ifc.in_imm = '0;
    ifc.addr_load = 1'b0; ifc.base_addr = '0; ifc.out_ready = 1'b1;

    // Pin the reference model to hand-encoded words
    pin = model_enc(1, 0, 0, 1, 0, 0, 32'd5);
    chk("model_itype", pin[31:0], 32'h0050_0093);
    pin = model_enc(4, 0, 0, 0, 1, 2, 32'hFFFF_FFF8);
    chk("model_branch", pin[31:0], 32'hFE20_8CE3);
    pin = model_enc(5, 0, 0, 1, 0, 0, 32'h0000_0800);
    chk("model_jal", pin[31:0], 32'h0010_00EF);
    pin = model_enc(1, 0, 0, 1, 0, 0, 32'h0000_0800);
    chk("model_itype_range", {31'd0, pin[32]}, 32'd1);

    #2;
    chk_en = 1'b1;
    do_reset();

    send_chk("itype", 4'd1, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5, 32'h0050_0093, RA, 1'b0);
    send_chk("rtype_sub", 4'd0, 3'd0, 1'b1, 5'd3, 5'd1, 5'd2, 32'd0, 32'h4020_81B3, RA + 4, 1'b0);
    send_chk("branch", 4'd4, 3'd0, 1'b0, 5'd0, 5'd1, 5'd2, 32'hFFFF_FFF8, 32'hFE20_8CE3, RA + 8, 1'b0);
    send_chk("jal", 4'd5, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'h0000_0800, 32'h0010_00EF, RA + 12, 1'b0);
    send_chk("lui", 4'd7, 3'd0, 1'b0, 5'd5, 5'd0, 5'd0, 32'h1234_5000, 32'h1234_52B7, RA + 16, 1'b0);
    send_chk("lui_bad", 4'd7, 3'd0, 1'b0, 5'd5, 5'd0, 5'd0, 32'h1234_5001, 32'h0000_0013, RA + 20, 1'b1);
    chk("lui_bad_errcnt", 32'(ifc.err_count), 32'd1);

    ifc.in_valid = 1'b0;
    tick();
    do_reset();
    send_chk("bad_class", 4'd12, 3'd0, 1'b0, 5'd1, 5'd1, 5'd1, 32'd0, 32'h0000_0013, RA, 1'b1);
    send_chk("branch_odd", 4'd4, 3'd0, 1'b0, 5'd0, 5'd1, 5'd2, 32'd3, 32'h0000_0013, RA + 4, 1'b1);
    send_chk("itype_0x800", 4'd1, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'h800, 32'h0000_0013, RA + 8, 1'b1);
    chk("three_err_count", 32'(ifc.err_count), 32'd3);

    // Backpressure: the pending word must wait, then land exactly once
    send_chk("bp_a", 4'd1, 3'd0, 1'b0, 5'd2, 5'd0, 5'd0, 32'd7, 32'h0070_0113, RA + 12, 1'b0);
    set_in(4'd1, 3'd0, 1'b0, 5'd3, 5'd0, 5'd0, 32'd9);
    ifc.out_ready = 1'b0;
    #1;
    for (int i = 0; i < 5; i++) begin
      chk("bp_in_ready", 32'(ifc.in_ready), 32'd0);
      chk("bp_hold_instr", ifc.out_instr, 32'h0070_0113);
      chk("bp_hold_addr", ifc.out_addr, RA + 12);
      tick();
    end
    ifc.out_ready = 1'b1;
    #1;
    chk("bp_release_ready", 32'(ifc.in_ready), 32'd1);
    tick();
    chk("bp_b_instr", ifc.out_instr, 32'h0090_0193);
    chk("bp_b_addr", ifc.out_addr, RA + 16);
    ifc.in_valid = 1'b0;
    tick();
    chk("bp_drain_valid", 32'(ifc.out_valid), 32'd0);

    // Address load coincident with accept, then wrap past 2^32
    ifc.addr_load = 1'b1;
    ifc.base_addr = 32'hFFFF_FFFC;
    send_chk("load_wrap0", 4'd6, 3'd5, 1'b0, 5'd1, 5'd2, 5'd0, 32'hFFFF_FFFC, 32'hFFC1_00E7, 32'hFFFF_FFFC, 1'b0);
    ifc.addr_load = 1'b0;
    send_chk("load_wrap1", 4'd6, 3'd0, 1'b0, 5'd1, 5'd2, 5'd0, 32'd4, 32'h0041_00E7, 32'h0000_0000, 1'b0);

    // Reset while streaming; counter must restart at RESET_ADDR
    do_reset();
    send_chk("post_reset", 4'd3, 3'd2, 1'b0, 5'd0, 5'd1, 5'd2, 32'hFFFF_FFFC, 32'hFE20_AE23, RA, 1'b0);

    // Randomized traffic; the negedge model checks every cycle
    for (int c = 0; c < 4000; c++) begin
      int unsigned mode;
      logic [31:0] imm;
      mode = $urandom_range(0, 5);
      case (mode)
        0: imm = $urandom;
        1: imm = 32'($urandom_range(0, 63));
        2: imm = 32'(int'($urandom_range(0, 8191)) - 4096);
        3: imm = $urandom & 32'hFFFF_F000;
        4: imm = 32'(int'($urandom_range(0, 2097151)) - 1048576);
        default: imm = 32'(int'($urandom_range(0, 4095)) - 2048);
      endcase
      if ($urandom_range(0, 2) != 0) imm[0] = 1'b0;
      set_in(($urandom_range(0, 7) != 0) ? 4'($urandom_range(0, 8)) : 4'($urandom_range(0, 15)),
             3'($urandom), 1'($urandom_range(0, 4) == 0), 5'($urandom), 5'($urandom),
             5'($urandom), imm);
      ifc.in_valid  = ($urandom_range(0, 3) != 0);
      ifc.out_ready = ($urandom_range(0, 3) != 0);
      ifc.addr_load = ($urandom_range(0, 15) == 0);
      ifc.base_addr = $urandom;
      if ($urandom_range(0, 999) == 0) begin
        ifc.in_valid = 1'b0;
        do_reset();
      end
      tick();
    end

    ifc.in_valid  = 1'b0;
    ifc.addr_load = 1'b0;
    ifc.out_ready = 1'b1;
    tick();
    tick();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
- Assembles 32-bit RV32I base instruction words from decoded fields: instruction class, register indices, funct3, alt bit and a full-width immediate. It is the inverse of the pipeline's opcode decoder.
- Feeds the instruction-memory preload and self-test path, which writes program images through a valid/ready stream.
- Registered output, 1-cycle latency, running word address counter, per-word field legality checking with an error counter.

Parameters:
- RESET_ADDR, 32'h0000_0000, address counter value after reset.
- ERR_CNT_W, 16, width of the saturating error counter.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- in_valid  input  1  input fields are valid.
- in_ready  output  1  block accepts the input this cycle.
- in_class  input  4  0=RTYPE 1=ITYPE 2=LOAD 3=STORE 4=BRANCH 5=JAL 6=JALR 7=LUI 8=AUIPC; 9-15 are illegal.
- in_funct3  input  3  funct3 field.
- in_alt  input  1  sets instr[30] (SUB/SRA/SRAI).
- in_rd, in_rs1, in_rs2  input  5 each  register indices.
- in_imm  input  32  byte-offset or value immediate, sign-extended.
- addr_load  input  1  load the address counter from base_addr.
- base_addr  input  32  new counter value.
- out_valid  output  1  out_instr, out_addr and out_err are valid.
- out_ready  input  1  downstream accepts the output.
- out_instr  output  32  encoded instruction word.
- out_addr  output  32  word address for out_instr.
- out_err  output  1  illegal fields; out_instr is forced to NOP.
- err_count  output  ERR_CNT_W  count of errored words, saturating.

Behaviour:
- Reset values: out_valid=0, out_instr=0, out_addr=0, out_err=0, err_count=0, address counter=RESET_ADDR. Reset is asynchronous and may occur mid-transfer; any held word is discarded.
- Handshake:
  - in_ready = !out_valid || out_ready (combinational). An input is accepted when in_valid && in_ready.
  - On accept, the output register loads the encoded word and out_valid=1 on the next edge. Latency is 1 cycle.
  - If out_ready=1 with no accept, out_valid goes to 0.
  - While out_valid && !out_ready, all outputs hold stable.
  - Back-to-back accepts give full throughput.
- Address counter:
  - Each accepted word takes the current counter value as out_addr; the counter then advances by 4 (mod 2^32 wrap).
  - If addr_load is asserted alone, counter=base_addr.
  - If addr_load and accept occur in the same cycle, the word takes base_addr and the counter becomes base_addr+4.
- Encodings (opcode in [6:0]):
  - RTYPE 0110011: {alt?0100000:0000000, rs2, rs1, f3, rd}. alt is legal only with f3=000 or 101.
  - ITYPE 0010011: {imm[11:0], rs1, f3, rd}.
    - f3=001: [31:25]=0; requires imm[11:5]=0 and alt=0.
    - f3=101: [31:25]=alt?0100000:0; requires imm[11:5]=0.
    - Other f3 with alt=1 is an error.
  - LOAD 0000011: {imm[11:0], rs1, f3, rd}. f3 must be in {000,001,010,100,101}.
  - STORE 0100011: {imm[11:5], rs2, rs1, f3, imm[4:0]}. f3 must be in {000,001,010}.
  - BRANCH 1100011: {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11]}. f3 must not be 010 or 011; imm[0] must be 0.
  - JAL 1101111: {imm[20], imm[10:1], imm[11], imm[19:12], rd}. imm[0] must be 0.
  - JALR 1100111: {imm[11:0], rs1, 000, rd}. in_funct3 is ignored.
  - LUI 0110111 / AUIPC 0010111: {imm[31:12], rd}. Requires imm[11:0]=0.
- Range rules: the immediate must be the sign extension of its field width. Widths are 12 bits (I/LOAD/STORE/JALR), 13 bits (BRANCH) and 21 bits (JAL); upper bits not matching the sign bit are an error.
- Unused inputs for a class are don't-care and never raise an error.
- On any error or illegal class: out_instr=32'h0000_0013, out_err=1, the word still consumes an address, and err_count increments by 1 when the word is accepted, saturating at all-ones.
- out_err is registered alongside out_instr and has the same hold rules.

Test Plan:
- ITYPE f3=000 rd=1 rs1=0 imm=5, out_ready=1 -> out_instr=0x00500093 one cycle after accept, out_addr=RESET_ADDR, out_err=0.
- RTYPE f3=000 alt=1 rd=3 rs1=1 rs2=2, then BRANCH f3=000 rs1=1 rs2=2 imm=-8 back-to-back -> 0x402081B3 then 0xFE208CE3; out_addr increments by 4; in_ready stays 1.
- JAL rd=1 imm=0x800 -> 0x001000EF. LUI rd=5 imm=0x12345000 -> 0x123452B7. LUI imm=0x12345001 -> 0x00000013, out_err=1, err_count=1.
- Illegal class 12, then BRANCH imm=3, then ITYPE imm=0x800 -> three NOPs with out_err=1; err_count=3; out_addr still increments on each word.
- Backpressure: hold out_ready=0 for 5 cycles with in_valid=1 -> in_ready=0, outputs stable; release -> the pending input is accepted the same cycle and appears next cycle, with no loss or duplicate.
- addr_load with base_addr=0xFFFF_FFFC in the same cycle as accept -> word at 0xFFFFFFFC, next word at 0x00000000. rst_n low mid-stream -> out_valid=0 immediately, counter=RESET_ADDR, err_count=0.
